// File: rtl/axis_pipeline_register.sv
// axis_pipeline_register
//   AXI4-Stream register slice chain: LENGTH cascaded stages of one type
//   (REG_TYPE 0 bypass, 1 simple/bubble, 2 skid/full-rate). Adds a synchronous
//   flush that discards all buffered beats and a registered occupancy count.
//   Every stage's tready is registered, so there is no combinational path
//   from m_axis_tready to s_axis_tready.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               discard all buffered beats (gates s_tready/m_tvalid)
//   s_axis_t*           input stream (tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser)
//   m_axis_t*           output stream
//   occupancy           beats currently held across all stages
// Build option
//   AXIS_PIPELINE_STATS_EN: adds stat_beats/stat_stall 32-bit counters
//   (output beats accepted / output cycles stalled), cleared only by rst.
module axis_pipeline_register #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int LAST_ENABLE = 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int REG_TYPE    = 2,
  parameter int LENGTH      = 2,
  parameter int OCC_WIDTH   = $clog2(2 * LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [OCC_WIDTH-1:0]  occupancy
`ifdef AXIS_PIPELINE_STATS_EN
  ,
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_stall
`endif
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  logic [PW-1:0] s_payload;
  logic [PW-1:0] m_payload;

  // All sideband fields travel together; disabled fields are replaced by
  // constants on the output side and drop out in synthesis.
  assign s_payload = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                      s_axis_tid, s_axis_tdest, s_axis_tuser};

  logic [DATA_WIDTH-1:0] o_data;
  logic [KEEP_WIDTH-1:0] o_keep;
  logic                  o_last;
  logic [ID_WIDTH-1:0]   o_id;
  logic [DEST_WIDTH-1:0] o_dest;
  logic [USER_WIDTH-1:0] o_user;

  assign {o_data, o_keep, o_last, o_id, o_dest, o_user} = m_payload;

  assign m_axis_tdata = o_data;
  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? o_keep : '1;
  assign m_axis_tlast = (LAST_ENABLE != 0) ? o_last : 1'b1;
  assign m_axis_tid   = (ID_ENABLE   != 0) ? o_id   : '0;
  assign m_axis_tdest = (DEST_ENABLE != 0) ? o_dest : '0;
  assign m_axis_tuser = (USER_ENABLE != 0) ? o_user : '0;

  generate
    if (REG_TYPE == 0) begin : g_bypass
      assign m_payload     = s_payload;
      assign m_axis_tvalid = s_axis_tvalid;
      assign s_axis_tready = m_axis_tready;
      assign occupancy     = '0;
    end else begin : g_chain
      // Node k is the input of stage k; node LENGTH is the chain output.
      logic [PW-1:0]  pl [0:LENGTH];
      logic [LENGTH:0] vl;
      logic [LENGTH:0] rl;
      logic            s_fire;
      logic            m_fire;
      logic [OCC_WIDTH-1:0] occ_q, occ_d;

      assign pl[0]      = s_payload;
      assign vl[0]      = s_axis_tvalid;
      assign rl[LENGTH] = m_axis_tready;

      assign s_axis_tready = rl[0] & ~flush;
      assign m_axis_tvalid = vl[LENGTH] & ~flush;
      assign m_payload     = pl[LENGTH];

      for (genvar k = 0; k < LENGTH; k++) begin : g_stage
        if (REG_TYPE == 2) begin : g_skid
          logic [PW-1:0] main_q, main_d, temp_q, temp_d;
          logic          main_v_q, main_v_d, temp_v_q, temp_v_d;
          logic          rdy_q, rdy_d;

          // Ready is computed one cycle early so it can be registered; the
          // temp slot catches the beat accepted while downstream stalls.
          always_comb begin
            main_d   = main_q;
            temp_d   = temp_q;
            main_v_d = main_v_q;
            temp_v_d = temp_v_q;
            rdy_d    = rl[k+1] | (~temp_v_q & (~main_v_q | ~vl[k]));
            if (rdy_q) begin
              if (rl[k+1] | ~main_v_q) begin
                main_v_d = vl[k];
                main_d   = pl[k];
              end else begin
                temp_v_d = vl[k];
                temp_d   = pl[k];
              end
            end else if (rl[k+1]) begin
              main_v_d = temp_v_q;
              main_d   = temp_q;
              temp_v_d = 1'b0;
            end
            if (flush) begin
              main_v_d = 1'b0;
              temp_v_d = 1'b0;
            end
          end

          always_ff @(posedge clk) begin
            if (rst) begin
              main_v_q <= 1'b0;
              temp_v_q <= 1'b0;
              rdy_q    <= 1'b0;
            end else begin
              main_v_q <= main_v_d;
              temp_v_q <= temp_v_d;
              rdy_q    <= rdy_d;
            end
          end

          always_ff @(posedge clk) begin
            main_q <= main_d;
            temp_q <= temp_d;
          end

          assign pl[k+1] = main_q;
          assign vl[k+1] = main_v_q;
          assign rl[k]   = rdy_q;
        end else begin : g_simple
          logic [PW-1:0] data_q, data_d;
          logic          v_q, v_d;
          logic          rdy_q, rdy_d;

          // rdy_q high implies the stage is empty, so loading never overwrites.
          always_comb begin
            data_d = data_q;
            v_d    = v_q;
            if (rdy_q) begin
              v_d    = vl[k];
              data_d = pl[k];
            end else if (rl[k+1]) begin
              v_d = 1'b0;
            end
            if (flush) begin
              v_d = 1'b0;
            end
            rdy_d = ~v_d;
          end

          always_ff @(posedge clk) begin
            if (rst) begin
              v_q   <= 1'b0;
              rdy_q <= 1'b0;
            end else begin
              v_q   <= v_d;
              rdy_q <= rdy_d;
            end
          end

          always_ff @(posedge clk) begin
            data_q <= data_d;
          end

          assign pl[k+1] = data_q;
          assign vl[k+1] = v_q;
          assign rl[k]   = rdy_q;
        end
      end

      assign s_fire = s_axis_tvalid & s_axis_tready;
      assign m_fire = m_axis_tvalid & m_axis_tready;

      always_comb begin
        occ_d = occ_q;
        if (s_fire & ~m_fire) begin
          occ_d = occ_q + OCC_WIDTH'(1);
        end else if (~s_fire & m_fire) begin
          occ_d = occ_q - OCC_WIDTH'(1);
        end
        if (flush) begin
          occ_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          occ_q <= '0;
        end else begin
          occ_q <= occ_d;
        end
      end

      assign occupancy = occ_q;
    end
  endgenerate

`ifdef AXIS_PIPELINE_STATS_EN
  logic [31:0] beats_q, beats_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    beats_d = beats_q;
    stall_d = stall_q;
    if (m_axis_tvalid & m_axis_tready) begin
      beats_d = beats_q + 32'd1;
    end
    if (m_axis_tvalid & ~m_axis_tready) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  assign stat_beats = beats_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_axis_pipeline_register.sv
// Directed bench for axis_pipeline_register: a skid chain (REG_TYPE=2,
// LENGTH=3) and a simple chain (REG_TYPE=1, LENGTH=2) share clk/rst.
// Inputs are driven 1 time unit after the rising edge; outputs are
// compared on the falling edge.
module tb_axis_pipeline_register;

  logic clk;
  logic rst;
  logic flush2;
  logic flush1;

  logic [7:0] s2_tdata, m2_tdata, s1_tdata, m1_tdata;
  logic [0:0] s2_tkeep, m2_tkeep, s1_tkeep, m1_tkeep;
  logic       s2_tvalid, s2_tready, m2_tvalid, m2_tready;
  logic       s1_tvalid, s1_tready, m1_tvalid, m1_tready;
  logic       s2_tlast, m2_tlast, s1_tlast, m1_tlast;
  logic [7:0] s2_tid, m2_tid, s1_tid, m1_tid;
  logic [7:0] s2_tdest, m2_tdest, s1_tdest, m1_tdest;
  logic [0:0] s2_tuser, m2_tuser, s1_tuser, m1_tuser;
  logic [2:0] occ2, occ1;
`ifdef AXIS_PIPELINE_STATS_EN
  logic [31:0] beats2, stall2, beats1, stall1;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int cnt     = 0;

  axis_pipeline_register #(.REG_TYPE(2), .LENGTH(3)) u_skid (
    .clk(clk), .rst(rst), .flush(flush2),
    .s_axis_tdata(s2_tdata), .s_axis_tkeep(s2_tkeep), .s_axis_tvalid(s2_tvalid),
    .s_axis_tready(s2_tready), .s_axis_tlast(s2_tlast), .s_axis_tid(s2_tid),
    .s_axis_tdest(s2_tdest), .s_axis_tuser(s2_tuser),
    .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tvalid(m2_tvalid),
    .m_axis_tready(m2_tready), .m_axis_tlast(m2_tlast), .m_axis_tid(m2_tid),
    .m_axis_tdest(m2_tdest), .m_axis_tuser(m2_tuser),
    .occupancy(occ2)
`ifdef AXIS_PIPELINE_STATS_EN
    , .stat_beats(beats2), .stat_stall(stall2)
`endif
  );

  axis_pipeline_register #(.REG_TYPE(1), .LENGTH(2)) u_simple (
    .clk(clk), .rst(rst), .flush(flush1),
    .s_axis_tdata(s1_tdata), .s_axis_tkeep(s1_tkeep), .s_axis_tvalid(s1_tvalid),
    .s_axis_tready(s1_tready), .s_axis_tlast(s1_tlast), .s_axis_tid(s1_tid),
    .s_axis_tdest(s1_tdest), .s_axis_tuser(s1_tuser),
    .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid),
    .m_axis_tready(m1_tready), .m_axis_tlast(m1_tlast), .m_axis_tid(m1_tid),
    .m_axis_tdest(m1_tdest), .m_axis_tuser(m1_tuser),
    .occupancy(occ1)
`ifdef AXIS_PIPELINE_STATS_EN
    , .stat_beats(beats1), .stat_stall(stall1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int in_i, out_i, first_in, first_out, last_out, acc, k;
    bit got;

    rst = 1'b1; flush2 = 1'b0; flush1 = 1'b0;
    s2_tdata = '0; s2_tkeep = '0; s2_tvalid = 1'b0; s2_tlast = 1'b0;
    s2_tid = 8'h5A; s2_tdest = 8'hC3; s2_tuser = '0; m2_tready = 1'b0;
    s1_tdata = '0; s1_tkeep = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
    s1_tid = '0; s1_tdest = '0; s1_tuser = '0; m1_tready = 1'b0;

    // ---- Reset ----
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m2_tvalid", m2_tvalid, 0);
    chk("rst_occ2", occ2, 0);
    chk("rst_s2_tready", s2_tready, 0);
    chk("rst_m1_tvalid", m1_tvalid, 0);
    chk("rst_s1_tready", s1_tready, 0);
    drive_pt();
    @(negedge clk);
    chk("rst_s2_tready_rise", s2_tready, 1);
    chk("rst_s1_tready_rise", s1_tready, 1);
    drive_pt();

    // ---- Stream 100 beats through the skid chain ----
    m2_tready = 1'b1;
    in_i = 0; out_i = 0; first_in = -1; first_out = -1; last_out = -1;
    for (int c = 0; c < 400 && out_i < 100; c++) begin
      s2_tvalid = (in_i < 100);
      s2_tdata  = in_i[7:0];
      s2_tlast  = (in_i % 4 == 3);
      s2_tuser  = in_i[0];
      @(negedge clk);
      if (m2_tvalid) begin
        chk("stream_data", m2_tdata, out_i[7:0]);
        chk("stream_last", m2_tlast, (out_i % 4 == 3));
        chk("stream_user", m2_tuser, out_i[0]);
        if (out_i == 0) begin
          first_out = cnt;
          chk("stream_tid_zero", m2_tid, 0);
          chk("stream_tdest_zero", m2_tdest, 0);
          chk("stream_tkeep_ones", m2_tkeep, 1);
        end
        last_out = cnt;
        out_i++;
      end
      chk("stream_occ_le3", (occ2 <= 3'd3), 1);
      if (s2_tvalid && s2_tready) begin
        if (in_i == 0) first_in = cnt;
        in_i++;
      end
      drive_pt();
    end
    s2_tvalid = 1'b0;
    chk("stream_count", out_i, 100);
    chk("stream_latency", first_out - first_in, 3);
    chk("stream_rate", last_out - first_out, 99);
    @(negedge clk);
    chk("stream_occ_drained", occ2, 0);
    drive_pt();

    // ---- Backpressure: capacity 6 ----
    m2_tready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      s2_tvalid = 1'b1;
      s2_tdata  = 8'(8'h10 + acc);
      @(negedge clk);
      if (s2_tvalid && s2_tready) acc++;
      if (c == 8) chk("bp_head_stable", m2_tdata, 8'h10);
      drive_pt();
    end
    s2_tvalid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", acc, 6);
    chk("bp_occ", occ2, 6);
    chk("bp_s_tready", s2_tready, 0);
    chk("bp_m_tvalid", m2_tvalid, 1);
    chk("bp_head", m2_tdata, 8'h10);
    drive_pt();
    m2_tready = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m2_tvalid) begin
        chk("bp_drain_data", m2_tdata, 8'(8'h10 + k));
        k++;
      end
      drive_pt();
    end
    chk("bp_drain_count", k, 6);
    @(negedge clk);
    chk("bp_occ_empty", occ2, 0);
    drive_pt();

    // ---- Simple type: 1 beat per 2 cycles, no loss ----
    m1_tready = 1'b1;
    in_i = 0; out_i = 0; last_out = -1;
    for (int c = 0; c < 70; c++) begin
      s1_tvalid = (c < 60);
      s1_tdata  = in_i[7:0];
      @(negedge clk);
      if (m1_tvalid) begin
        chk("simple_data", m1_tdata, out_i[7:0]);
        if (out_i > 0) chk("simple_spacing", cnt - last_out, 2);
        last_out = cnt;
        out_i++;
      end
      if (s1_tvalid && s1_tready) in_i++;
      drive_pt();
    end
    s1_tvalid = 1'b0;
    chk("simple_accepted", in_i, 30);
    chk("simple_no_loss", out_i, 30);

    // ---- Flush ----
    m2_tready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      s2_tvalid = (acc < 4);
      s2_tdata  = 8'(8'h20 + acc);
      @(negedge clk);
      if (s2_tvalid && s2_tready) acc++;
      drive_pt();
    end
    s2_tvalid = 1'b0;
    @(negedge clk);
    chk("fl_loaded_occ", occ2, 4);
    chk("fl_loaded_head", m2_tdata, 8'h20);
    drive_pt();
    flush2 = 1'b1;
    @(negedge clk);
    chk("fl_gate_s_tready", s2_tready, 0);
    chk("fl_gate_m_tvalid", m2_tvalid, 0);
    drive_pt();
    flush2 = 1'b0;
    @(negedge clk);
    chk("fl_occ_zero", occ2, 0);
    chk("fl_m_tvalid_zero", m2_tvalid, 0);
    drive_pt();
    m2_tready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      s2_tvalid = 1'b1;
      s2_tdata  = 8'hA5;
      @(negedge clk);
      if (s2_tready) got = 1'b1;
      drive_pt();
    end
    s2_tvalid = 1'b0;
    chk("fl_a5_accepted", got, 1);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (m2_tvalid) begin
        got = 1'b1;
        chk("fl_first_after", m2_tdata, 8'hA5);
      end
      drive_pt();
    end
    chk("fl_a5_emerged", got, 1);

`ifdef AXIS_PIPELINE_STATS_EN
    // ---- Statistics: 10 beats, 5 stall cycles ----
    rst = 1'b1;
    drive_pt();
    rst = 1'b0;
    drive_pt();
    drive_pt();
    m2_tready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      s2_tvalid = 1'b1;
      s2_tdata  = 8'h00;
      @(negedge clk);
      if (s2_tready) got = 1'b1;
      drive_pt();
    end
    s2_tvalid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (m2_tvalid) got = 1'b1;
      else drive_pt();
    end
    chk("st_head_visible", got, 1);
    repeat (5) @(posedge clk);
    #1 m2_tready = 1'b1;
    in_i = 0; out_i = 0;
    for (int c = 0; c < 60 && out_i < 10; c++) begin
      s2_tvalid = (in_i < 9);
      s2_tdata  = 8'(in_i + 1);
      @(negedge clk);
      if (m2_tvalid) out_i++;
      if (s2_tvalid && s2_tready) in_i++;
      drive_pt();
    end
    s2_tvalid = 1'b0;
    drive_pt();
    @(negedge clk);
    chk("st_beats", beats2, 10);
    chk("st_stall", stall2, 5);
    drive_pt();
    flush2 = 1'b1;
    drive_pt();
    flush2 = 1'b0;
    drive_pt();
    @(negedge clk);
    chk("st_beats_after_flush", beats2, 10);
    chk("st_stall_after_flush", stall2, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
